// File: rtl/console_writer.sv
`default_nettype none
// ============================================================================
// Module      : console_writer
// Description : Text-console writer for a character frame buffer. Accepts a
//               byte stream of printable characters and control codes
//               (BS, LF, FF, CR), tracks a cursor and issues one write per
//               cycle into a 2048-entry {row,col} addressed character RAM.
//               Clears the whole buffer after reset and on request.
//               Optional feature macro: CONSOLE_LINECLEAR_EN -- blanks the
//               new row (64 cells) on every row advance.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk    : pixel clock, single clock domain
//   i_rst    : asynchronous active-high reset
//   i_valid  : character byte offered
//   o_ready  : byte accepted this cycle when i_valid is also high
//   i_char   : character or control code
//   i_attr   : colour attribute {irgb back, irgb fore}
//   i_clear  : single-cycle clear-screen request
//   o_busy   : a clear sequence is running
//   o_ada    : char buffer write address {row[4:0], col[5:0]}
//   o_din    : char buffer write data {attr, char}
//   o_cea    : char buffer write enable
//   o_col    : cursor column
//   o_row    : cursor row
// ============================================================================
module console_writer #(
    parameter int          COLS       = 60,
    parameter int          ROWS       = 17,
    parameter logic [7:0]  BLANK_ATTR = 8'h07
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [7:0]  i_char,
    input  logic [7:0]  i_attr,
    input  logic        i_clear,
    output logic        o_busy,
    output logic [10:0] o_ada,
    output logic [15:0] o_din,
    output logic        o_cea,
    output logic [5:0]  o_col,
    output logic [4:0]  o_row
);

`ifdef CONSOLE_LINECLEAR_EN
    typedef enum logic [1:0] {
        CLR_ALL  = 2'd0,
        IDLE     = 2'd1,
        CLR_LINE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        CLR_ALL  = 2'd0,
        IDLE     = 2'd1
    } state_t;
`endif

    localparam logic [5:0]  C_LAST_COL = 6'(COLS - 1);
    localparam logic [4:0]  C_LAST_ROW = 5'(ROWS - 1);
    localparam logic [15:0] C_BLANK    = {BLANK_ATTR, 8'h20};

    state_t      r_state, w_state;
    logic [10:0] r_addr,  w_addr;   // clear sequencer address (low 6 bits for line clear)
    logic [5:0]  r_col,   w_col;
    logic [4:0]  r_row,   w_row;
    logic [10:0] r_ada,   w_ada;
    logic [15:0] r_din,   w_din;
    logic        r_cea,   w_cea;
    logic        w_adv;             // row advance requested this cycle
    logic [4:0]  w_next_row;

    assign w_next_row = (r_row == C_LAST_ROW) ? 5'd0 : r_row + 5'd1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= CLR_ALL;
            r_addr  <= 11'd0;
            r_col   <= 6'd0;
            r_row   <= 5'd0;
            r_ada   <= 11'd0;
            r_din   <= 16'd0;
            r_cea   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_addr  <= w_addr;
            r_col   <= w_col;
            r_row   <= w_row;
            r_ada   <= w_ada;
            r_din   <= w_din;
            r_cea   <= w_cea;
        end
    end

    always_comb begin
        w_state = r_state;
        w_addr  = r_addr;
        w_col   = r_col;
        w_row   = r_row;
        w_ada   = r_ada;
        w_din   = r_din;
        w_cea   = 1'b0;
        w_adv   = 1'b0;

        case (r_state)
            CLR_ALL: begin
                if (i_clear) begin
                    // Restart: the next issued write is address 0 again.
                    w_addr = 11'd0;
                end else begin
                    w_cea = 1'b1;
                    w_ada = r_addr;
                    w_din = C_BLANK;
                    if (r_addr == 11'h7FF) begin
                        w_state = IDLE;
                        w_addr  = 11'd0;
                        w_col   = 6'd0;
                        w_row   = 5'd0;
                    end else begin
                        w_addr = r_addr + 11'd1;
                    end
                end
            end

            IDLE: begin
                if (i_clear) begin
                    // Clear beats a simultaneously offered byte.
                    w_state = CLR_ALL;
                    w_addr  = 11'd0;
                end else if (i_valid) begin
                    case (i_char)
                        8'h0C: begin
                            w_state = CLR_ALL;
                            w_addr  = 11'd0;
                        end
                        8'h0D: w_col = 6'd0;
                        8'h0A: begin
                            w_col = 6'd0;
                            w_adv = 1'b1;
                        end
                        8'h08: begin
                            if (r_col != 6'd0) w_col = r_col - 6'd1;
                        end
                        default: begin
                            w_cea = 1'b1;
                            w_ada = {r_row, r_col};
                            w_din = {i_attr, i_char};
                            if (r_col == C_LAST_COL) begin
                                w_col = 6'd0;
                                w_adv = 1'b1;
                            end else begin
                                w_col = r_col + 6'd1;
                            end
                        end
                    endcase
                end
            end

`ifdef CONSOLE_LINECLEAR_EN
            CLR_LINE: begin
                if (i_clear) begin
                    w_state = CLR_ALL;
                    w_addr  = 11'd0;
                end else begin
                    w_cea = 1'b1;
                    w_ada = {r_row, r_addr[5:0]};
                    w_din = C_BLANK;
                    if (r_addr[5:0] == 6'd63) begin
                        w_state = IDLE;
                        w_addr  = 11'd0;
                    end else begin
                        w_addr = r_addr + 11'd1;
                    end
                end
            end
`endif

            default: begin
                w_state = CLR_ALL;
                w_addr  = 11'd0;
            end
        endcase

        // Row advance is shared by column wrap and LF.
        if (w_adv) begin
            w_row = w_next_row;
`ifdef CONSOLE_LINECLEAR_EN
            w_state = CLR_LINE;
            w_addr  = 11'd0;
`endif
        end
    end

    assign o_ready = (r_state == IDLE) & ~i_clear;
    assign o_busy  = (r_state != IDLE);
    assign o_ada   = r_ada;
    assign o_din   = r_din;
    assign o_cea   = r_cea;
    assign o_col   = r_col;
    assign o_row   = r_row;

endmodule
`default_nettype wire

// File: tb/tb_console_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_console_writer
// Description : Self-checking bench for console_writer. A cursor/write-list
//               model derived from the console rules predicts every buffer
//               write and the final cursor; a monitor records actual writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_console_writer;

    localparam int COLS = 60;
    localparam int ROWS = 17;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [7:0]  i_char = 8'h00;
    logic [7:0]  i_attr = 8'h00;
    logic        i_clear = 1'b0;
    logic        o_busy;
    logic [10:0] o_ada;
    logic [15:0] o_din;
    logic        o_cea;
    logic [5:0]  o_col;
    logic [4:0]  o_row;

    int checks = 0;
    int fails  = 0;

    // Model state: cursor as plain integers and the list of expected writes.
    int            mcol = 0;
    int            mrow = 0;
    logic [26:0]   exp_q[$];
    logic [26:0]   cap_q[$];

    console_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK_ATTR(8'h07)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_char(i_char), .i_attr(i_attr), .i_clear(i_clear), .o_busy(o_busy),
        .o_ada(o_ada), .o_din(o_din), .o_cea(o_cea), .o_col(o_col), .o_row(o_row)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_cea) cap_q.push_back({o_ada, o_din});
    end

    // ---------------- reference model ----------------
    task automatic m_clear();
        for (int a = 0; a < 2048; a++) exp_q.push_back({11'(a), 16'h0720});
        mcol = 0;
        mrow = 0;
    endtask

    task automatic m_rowadv();
        mrow = (mrow + 1) % ROWS;
`ifdef CONSOLE_LINECLEAR_EN
        for (int c = 0; c < 64; c++) exp_q.push_back({5'(mrow), 6'(c), 16'h0720});
`endif
    endtask

    task automatic m_char(input logic [7:0] c, input logic [7:0] a);
        if (c == 8'h0D) mcol = 0;
        else if (c == 8'h0A) begin mcol = 0; m_rowadv(); end
        else if (c == 8'h08) begin if (mcol > 0) mcol = mcol - 1; end
        else if (c == 8'h0C) m_clear();
        else begin
            exp_q.push_back({5'(mrow), 6'(mcol), a, c});
            mcol = mcol + 1;
            if (mcol == COLS) begin mcol = 0; m_rowadv(); end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic rand_print(output logic [7:0] c);
        do c = 8'($urandom_range(0, 255));
        while (c == 8'h08 || c == 8'h0A || c == 8'h0C || c == 8'h0D);
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] a);
        int n = 0;
        i_char = c; i_attr = a; i_valid = 1'b1;
        while (!o_ready && n < 3000) begin @(posedge i_clk); #1; n++; end
        if (!o_ready) begin
            checks++; fails++;
            $display("FAIL send_timeout: o_ready=%b required 1", o_ready);
            i_valid = 1'b0;
        end else begin
            m_char(c, a);
            @(posedge i_clk); #1;
            i_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!o_ready && n < 3000) begin @(posedge i_clk); #1; n++; end
        checks++;
        if (o_ready !== 1'b1) begin
            fails++;
            $display("FAIL idle_timeout: o_ready=%b required 1", o_ready);
        end
    endtask

    task automatic pulse_clear();
        i_clear = 1'b1;
        @(posedge i_clk); #1;
        i_clear = 1'b0;
    endtask

    // Flushes both write lists; reports counts and index mismatches.
    task automatic drain(output int got_n, output int exp_n, output int bad);
        int m;
        @(negedge i_clk); #1;
        got_n = cap_q.size();
        exp_n = exp_q.size();
        m = (got_n < exp_n) ? got_n : exp_n;
        bad = 0;
        for (int k = 0; k < m; k++) if (cap_q[k] !== exp_q[k]) bad++;
        cap_q.delete();
        exp_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int g, e, b;
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if ({o_cea, o_ada, o_din, o_busy, o_ready, o_col, o_row} !== {1'b0, 11'd0, 16'd0, 1'b1, 1'b0, 6'd0, 5'd0}) begin
            fails++;
            $display("FAIL reset_state: cea=%b ada=%h din=%h busy=%b ready=%b col=%0d row=%0d required 0/000/0000/1/0/0/0",
                     o_cea, o_ada, o_din, o_busy, o_ready, o_col, o_row);
        end
        // Reset in the middle of the power-up clear discards it.
        i_rst = 1'b0;
        repeat (500) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        #1;
        checks++;
        if (o_cea !== 1'b0 || o_ada !== 11'd0 || o_busy !== 1'b1) begin
            fails++;
            $display("FAIL midseq_reset: cea=%b ada=%h busy=%b required 0/000/1", o_cea, o_ada, o_busy);
        end
        @(posedge i_clk); #1;
        cap_q.delete();
        exp_q.delete();
        i_rst = 1'b0;
        m_clear();
        wait_idle();
        drain(g, e, b);
        checks++;
        if (g !== e) begin fails++; $display("FAIL powerup_count: got %0d writes required %0d", g, e); end
        checks++;
        if (b !== 0) begin fails++; $display("FAIL powerup_data: %0d bad writes required 0", b); end
        checks++;
        if (o_col !== 6'd0 || o_row !== 5'd0 || o_busy !== 1'b0) begin
            fails++;
            $display("FAIL powerup_cursor: col=%0d row=%0d busy=%b required 0/0/0", o_col, o_row, o_busy);
        end
    endtask

    task automatic test_single_char();
        int g, e, b;
        send(8'h41, 8'h1E);
        checks++;
        if (o_cea !== 1'b1 || o_ada !== 11'd0 || o_din !== 16'h1E41 || o_col !== 6'd1) begin
            fails++;
            $display("FAIL char_A: cea=%b ada=%h din=%h col=%0d required 1/000/1e41/1", o_cea, o_ada, o_din, o_col);
        end
        @(posedge i_clk); #1;
        checks++;
        if (o_cea !== 1'b0 || o_ada !== 11'd0 || o_din !== 16'h1E41) begin
            fails++;
            $display("FAIL hold_after_write: cea=%b ada=%h din=%h required 0/000/1e41", o_cea, o_ada, o_din);
        end
        drain(g, e, b);
        checks++;
        if (g !== e || b !== 0) begin fails++; $display("FAIL char_A_list: got %0d/%0d bad %0d", g, e, b); end
    endtask

    task automatic test_row_wrap();
        int g, e, b;
        logic [7:0] c;
        pulse_clear();
        m_clear();
        wait_idle();
        for (int k = 0; k < COLS; k++) begin
            rand_print(c);
            send(c, 8'($urandom_range(0, 255)));
        end
        checks++;
        if (o_cea !== 1'b1 || o_ada !== {5'd0, 6'd59}) begin
            fails++;
            $display("FAIL wrap_last_write: cea=%b ada=%h required 1/03b", o_cea, o_ada);
        end
        checks++;
`ifdef CONSOLE_LINECLEAR_EN
        if (o_ready !== 1'b0) begin fails++; $display("FAIL wrap_ready: o_ready=%b required 0", o_ready); end
`else
        if (o_ready !== 1'b1) begin fails++; $display("FAIL wrap_ready: o_ready=%b required 1", o_ready); end
`endif
        wait_idle();
        drain(g, e, b);
        checks++;
        if (g !== e || b !== 0) begin fails++; $display("FAIL wrap_list: got %0d/%0d writes bad %0d", g, e, b); end
        checks++;
        if (o_col !== 6'd0 || o_row !== 5'd1) begin
            fails++;
            $display("FAIL wrap_cursor: col=%0d row=%0d required 0/1", o_col, o_row);
        end
    endtask

    task automatic test_lf_wrap();
        int g, e, b;
        for (int k = 0; k < 15; k++) send(8'h0A, 8'h00);
        for (int k = 0; k < 5; k++) send(8'h30 + 8'(k), 8'h2F);
        wait_idle();
        drain(g, e, b);
        checks++;
        if (o_col !== 6'd5 || o_row !== 5'd16 || g !== e || b !== 0) begin
            fails++;
            $display("FAIL lf_setup: col=%0d row=%0d writes %0d/%0d bad %0d required 5/16", o_col, o_row, g, e, b);
        end
        send(8'h0A, 8'h00);
        wait_idle();
        drain(g, e, b);
        checks++;
        if (o_col !== 6'd0 || o_row !== 5'd0) begin
            fails++;
            $display("FAIL lf_wrap_cursor: col=%0d row=%0d required 0/0", o_col, o_row);
        end
        checks++;
        if (g !== e || b !== 0) begin fails++; $display("FAIL lf_wrap_list: got %0d/%0d bad %0d", g, e, b); end
    endtask

    task automatic test_bs_cr_clear();
        int g, e, b;
        for (int k = 0; k < 3; k++) send(8'h0A, 8'h00);
        wait_idle();
        drain(g, e, b);
        send(8'h08, 8'h00);
        send(8'h0D, 8'h00);
        wait_idle();
        drain(g, e, b);
        checks++;
        if (o_col !== 6'd0 || o_row !== 5'd3 || g !== 0) begin
            fails++;
            $display("FAIL bs_cr: col=%0d row=%0d writes=%0d required 0/3/0", o_col, o_row, g);
        end
        i_valid = 1'b1; i_char = 8'h55; i_attr = 8'h11; i_clear = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b0) begin fails++; $display("FAIL clear_wins_ready: o_ready=%b required 0", o_ready); end
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_clear = 1'b0;
        m_clear();
        wait_idle();
        drain(g, e, b);
        checks++;
        if (g !== e || b !== 0 || o_col !== 6'd0 || o_row !== 5'd0) begin
            fails++;
            $display("FAIL clear_wins: writes %0d/%0d bad %0d col=%0d row=%0d", g, e, b, o_col, o_row);
        end
    endtask

    task automatic test_clear_restart();
        int g, e, b, n;
        send(8'h5A, 8'h0F);
        pulse_clear();
        n = 0;
        while (!(o_cea === 1'b1 && o_ada === 11'd999) && n < 3000) begin @(posedge i_clk); #1; n++; end
        checks++;
        if (o_ada !== 11'd999) begin fails++; $display("FAIL restart_reach: o_ada=%0d required 999", o_ada); end
        for (int a = 0; a < 1000; a++) exp_q.push_back({11'(a), 16'h0720});
        pulse_clear();
        m_clear();
        wait_idle();
        drain(g, e, b);
        checks++;
        if (g !== e || b !== 0) begin fails++; $display("FAIL restart_list: got %0d/%0d writes bad %0d", g, e, b); end
    endtask

    task automatic test_back_to_back_random();
        int g, e, b, r;
        logic [7:0] c;
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 199);
            if (r < 140) rand_print(c);
            else if (r < 155) c = 8'h0D;
            else if (r < 175) c = 8'h08;
            else if (r < 197) c = 8'h0A;
            else c = 8'h0C;
            send(c, 8'($urandom_range(0, 255)));
        end
        wait_idle();
        drain(g, e, b);
        checks++;
        if (g !== e || b !== 0) begin fails++; $display("FAIL random_list: got %0d/%0d writes bad %0d", g, e, b); end
        checks++;
        if (o_col !== 6'(mcol) || o_row !== 5'(mrow)) begin
            fails++;
            $display("FAIL random_cursor: col=%0d row=%0d required %0d/%0d", o_col, o_row, mcol, mrow);
        end
    endtask

    initial begin
        test_reset();
        test_single_char();
        test_row_wrap();
        test_lf_wrap();
        test_bs_cr_clear();
        test_clear_restart();
        test_back_to_back_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
